// File: rtl/sobel_edge_contour.sv
// sobel_edge_contour: 3x3 Sobel gradient magnitude with threshold over a raster pixel stream.
// Define SOBEL_BINARY_EN to get a binary (00/FF) thresholded output instead of saturated magnitude.
module sobel_edge_contour #(
    parameter int unsigned IMG_WIDTH  = 10,
    parameter int unsigned IMG_HEIGHT = 10,
    parameter int unsigned THRESH     = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sof,
    input  logic [7:0] in_pixel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_pixel,
    output logic       out_sof,
    output logic       out_eof
);
    localparam int unsigned CW   = $clog2(IMG_WIDTH);
    localparam int unsigned RW   = $clog2(IMG_HEIGHT);
    localparam int unsigned NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned OW   = $clog2(NPIX + 1);
    localparam int unsigned MW   = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic [OW-1:0]       r_ocnt;

    logic [7:0]          r_lb0 [IMG_WIDTH];
    logic [7:0]          r_lb1 [IMG_WIDTH];
    logic [2:0][7:0]     r_wa;
    logic [2:0][7:0]     r_wb;
    logic [2:0][7:0]     w_col_new;

    logic [CW-1:0]       w_col;
    logic                w_acc;
    logic                w_start;
    logic                w_take;
    logic                w_emit;
    logic                w_flush_emit;
    logic                w_last;
    logic                w_has_out;
    logic                w_interior;

    logic [9:0]          w_sx_p;
    logic [9:0]          w_sx_n;
    logic [9:0]          w_sy_p;
    logic [9:0]          w_sy_n;
    logic [MW-1:0]       w_gx;
    logic [MW-1:0]       w_gy;
    logic [MW-1:0]       w_abs_gx;
    logic [MW-1:0]       w_abs_gy;
    logic [MW-1:0]       w_mag;
    logic [7:0]          w_res;

    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return 10'(a) + 10'({b, 1'b0}) + 10'(c);
    endfunction

    // A start-of-frame beat is always pixel (0,0), whatever the counters hold.
    assign w_col      = in_sof ? '0 : r_col;
    assign w_last     = (r_row == RW'(IMG_HEIGHT - 1)) && (r_col == CW'(IMG_WIDTH - 1));
    assign w_has_out  = (r_row != '0) && !((r_row == RW'(1)) && (r_col == '0));
    assign w_interior = (r_row >= RW'(2)) && (r_col >= CW'(2));

    // Window column entering from the right: [0]=row-2, [1]=row-1, [2]=live pixel.
    assign w_col_new  = {in_pixel, r_lb0[w_col], r_lb1[w_col]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        in_ready     = (r_state != ST_FLUSH) && (!out_valid || out_ready);
        w_acc        = in_valid && in_ready;
        w_start      = 1'b0;
        w_take       = 1'b0;
        w_emit       = 1'b0;
        w_flush_emit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_acc && in_sof) begin
                    w_start     = 1'b1;
                    w_take      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_acc) begin
                    w_take  = 1'b1;
                    w_start = in_sof;
                    w_emit  = !in_sof && w_has_out;
                    if (!in_sof && w_last) begin
                        w_state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                w_flush_emit = (r_ocnt != OW'(NPIX)) && (!out_valid || out_ready);
                if (out_valid && out_ready && out_eof) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Raster position of the next expected beat and running output index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row  <= '0;
            r_col  <= '0;
            r_ocnt <= '0;
        end else if (w_start) begin
            r_row  <= '0;
            r_col  <= CW'(1);
            r_ocnt <= '0;
        end else begin
            if (w_take) begin
                if (r_col == CW'(IMG_WIDTH - 1)) begin
                    r_col <= '0;
                    r_row <= w_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            if (w_emit || w_flush_emit) begin
                r_ocnt <= r_ocnt + OW'(1);
            end
        end
    end

    // Line buffers and window are not reset; only interior outputs ever read them.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_lb1[w_col] <= r_lb0[w_col];
            r_lb0[w_col] <= in_pixel;
            r_wa         <= r_wb;
            r_wb         <= w_col_new;
        end
    end

    always_comb begin
        w_sx_p   = wsum(w_col_new[0], w_col_new[1], w_col_new[2]);
        w_sx_n   = wsum(r_wa[0], r_wa[1], r_wa[2]);
        w_sy_p   = wsum(r_wa[2], r_wb[2], w_col_new[2]);
        w_sy_n   = wsum(r_wa[0], r_wb[0], w_col_new[0]);
        w_gx     = MW'(w_sx_p) - MW'(w_sx_n);
        w_gy     = MW'(w_sy_p) - MW'(w_sy_n);
        w_abs_gx = w_gx[MW-1] ? (~w_gx + MW'(1)) : w_gx;
        w_abs_gy = w_gy[MW-1] ? (~w_gy + MW'(1)) : w_gy;
        w_mag    = w_abs_gx + w_abs_gy;
    end

    always_comb begin
        w_res = 8'h00;
        if (w_interior && (w_mag >= MW'(THRESH))) begin
`ifdef SOBEL_BINARY_EN
            w_res = 8'hFF;
`else
            w_res = (w_mag > MW'(255)) ? 8'hFF : w_mag[7:0];
`endif
        end
    end

    // Output register: load a new result, or drop valid once the held one has transferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pixel <= 8'h00;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (w_emit || w_flush_emit) begin
            out_valid <= 1'b1;
            out_pixel <= w_emit ? w_res : 8'h00;
            out_sof   <= (r_ocnt == '0);
            out_eof   <= (r_ocnt == OW'(NPIX - 1));
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_edge_contour.sv
// Bench for sobel_edge_contour: table of step frames, reset/abort sequences and random frames
// checked against a whole-image Sobel reference model.
module tb_sobel_edge_contour;
    localparam int W    = 10;
    localparam int H    = 10;
    localparam int NPIX = W * H;
    localparam int TH   = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_sof;
    logic [7:0] in_pixel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pixel;
    logic       out_sof;
    logic       out_eof;

    always #5 clk = ~clk;

    sobel_edge_contour #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESH(TH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_sof(out_sof), .out_eof(out_eof)
    );

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        bit         rnd;
        logic [7:0] exp_edge;
    } vec_t;

    logic [7:0] img [H][W];
    logic [8:0] in_q  [$];
    logic [9:0] exp_q [$];
    logic [9:0] got_q [$];

    int   nvec = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   first_acc = -1;
    int   first_ov = -1;
    bit   rnd_ready = 1'b0;
    bit   stall_prev = 1'b0;
    logic [9:0] stall_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int px(input int r, input int c);
        return int'(img[r][c]);
    endfunction

    function automatic logic [7:0] ref_pixel(input int r, input int c);
        int gx, gy, mag;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'h00;
        gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
        gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag < TH) return 8'h00;
`ifdef SOBEL_BINARY_EN
        return 8'hFF;
`else
        return (mag > 255) ? 8'hFF : 8'(mag);
`endif
    endfunction

    // Expected {sof,eof,pixel} for the first n outputs of the current image.
    task automatic add_exp(input int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back({k == 0, k == NPIX - 1, ref_pixel(k / W, k % W)});
    endtask

    task automatic push_frame(input int nbeats);
        for (int k = 0; k < nbeats; k++)
            in_q.push_back({k == 0, img[k / W][k % W]});
    endtask

    task automatic drive();
        in_valid  = (in_q.size() > 0);
        {in_sof, in_pixel} = (in_q.size() > 0) ? in_q[0] : 9'h000;
        out_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    endtask

    // One clock: settle-time bookkeeping of both handshakes, then new stimulus after the edge.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (stall_prev) chk("stall_hold", {out_valid, out_sof, out_eof, out_pixel}, {1'b1, stall_val});
        stall_prev = out_valid && !out_ready;
        stall_val  = {out_sof, out_eof, out_pixel};
        if (out_valid && out_ready) got_q.push_back({out_sof, out_eof, out_pixel});
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (in_valid && in_ready) begin
            void'(in_q.pop_front());
            acc_cnt++;
            if (first_acc < 0) first_acc = cyc;
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_and_check(input string name);
        int n;
        int budget;
        n = exp_q.size();
        budget = 20 * n + 400;
        while (got_q.size() < n && budget > 0) begin
            cycle();
            budget--;
        end
        if (budget == 0) chk({name, "_timeout"}, 32'(got_q.size()), 32'(n));
        repeat (20) cycle();
        chk({name, "_count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_out%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic clear_all();
        in_q.delete();
        exp_q.delete();
        got_q.delete();
        first_acc = -1;
        first_ov  = -1;
    endtask

    task automatic set_step(input logic [7:0] lo, input logic [7:0] hi);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (c < 5) ? lo : hi;
    endtask

    vec_t tbl [5];
    int   budget;

    initial begin
        tbl[0] = '{lo: 8'h80, hi: 8'h80, rnd: 1'b0, exp_edge: 8'h00};
        tbl[1] = '{lo: 8'h00, hi: 8'hFF, rnd: 1'b0, exp_edge: 8'hFF};
`ifdef SOBEL_BINARY_EN
        tbl[2] = '{lo: 8'h10, hi: 8'h30, rnd: 1'b0, exp_edge: 8'hFF};
`else
        tbl[2] = '{lo: 8'h10, hi: 8'h30, rnd: 1'b0, exp_edge: 8'h80};
`endif
        tbl[3] = '{lo: 8'h10, hi: 8'h18, rnd: 1'b0, exp_edge: 8'h00};
        tbl[4] = '{lo: 8'h00, hi: 8'hFF, rnd: 1'b1, exp_edge: 8'hFF};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_pixel = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pixel", 32'(out_pixel), 32'd0);
        chk("rst_out_sof", 32'(out_sof), 32'd0);
        chk("rst_out_eof", 32'(out_eof), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            clear_all();
            rnd_ready = tbl[t].rnd;
            set_step(tbl[t].lo, tbl[t].hi);
            add_exp(NPIX);
            push_frame(NPIX);
            run_and_check($sformatf("step%0d", t));
            chk($sformatf("step%0d_r4c4", t), 32'(got_q[44][7:0]), 32'(tbl[t].exp_edge));
            chk($sformatf("step%0d_r4c5", t), 32'(got_q[45][7:0]), 32'(tbl[t].exp_edge));
            chk($sformatf("step%0d_r1c4", t), 32'(got_q[14][7:0]), 32'(tbl[t].exp_edge));
            chk($sformatf("step%0d_r4c3", t), 32'(got_q[43][7:0]), 32'd0);
            chk($sformatf("step%0d_r0c4", t), 32'(got_q[4][7:0]), 32'd0);
            chk($sformatf("step%0d_r9c5", t), 32'(got_q[95][7:0]), 32'd0);
            if (t == 0) chk("first_latency", 32'(first_ov - first_acc), 32'd12);
        end

        // Reset in the middle of a frame, then a clean flat frame.
        clear_all();
        rnd_ready = 1'b0;
        set_step(8'h80, 8'h80);
        push_frame(NPIX);
        acc_cnt = 0;
        budget = 1000;
        while (acc_cnt < 37 && budget > 0) begin
            cycle();
            budget--;
        end
        chk("midrst_reach37", 32'(acc_cnt), 32'd37);
        chk("midrst_busy", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_pixel", 32'(out_pixel), 32'd0);
        chk("midrst_sof_eof", 32'({out_sof, out_eof}), 32'd0);
        stall_prev = 1'b0;
        clear_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        add_exp(NPIX);
        push_frame(NPIX);
        drive();
        run_and_check("postrst");

        // Abort: 55 pixels of a random frame, then a full vertical-step frame.
        clear_all();
        rnd_ready = 1'b1;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'($urandom);
        for (int k = 0; k < 44; k++)
            exp_q.push_back({k == 0, 1'b0, ref_pixel(k / W, k % W)});
        push_frame(55);
        set_step(8'h00, 8'hFF);
        add_exp(NPIX);
        push_frame(NPIX);
        run_and_check("abort");

        // Idle junk beats, then three back-to-back random frames under random backpressure.
        clear_all();
        for (int j = 0; j < 3; j++) in_q.push_back({1'b0, 8'($urandom)});
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    img[r][c] = (f == 1) ? 8'($urandom_range(120, 100)) : 8'($urandom);
            add_exp(NPIX);
            push_frame(NPIX);
        end
        run_and_check("rand");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
